// File: rtl/uart_pkg.sv
// Shared UART transmitter definitions: FSM state encoding and frame constants.
package uart_pkg;

   localparam int DEFAULT_CLKS_PER_BIT = 434;
   localparam int DATA_BITS            = 8;
   localparam int STOP_BITS            = 1;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_READ   = 3'd1,
      S_LOAD   = 3'd2,
      S_START  = 3'd3,
      S_DATA   = 3'd4,
      S_PARITY = 3'd5,
      S_STOP   = 3'd6
   } state_e;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the last cycle of each bit.
module uart_baud_cnt #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic clk,
   input  logic rstn,
   input  logic clear,
   input  logic en,
   output logic bit_done
);

   localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      end
   end

   assign bit_done = en && !clear && (cnt_q == LAST);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter draining a one-cycle-latency byte FIFO into back-to-back 8N1/8E1 frames.
// Handshake: fifo_rd_en is a single-cycle pop issued only when fifo_empty was seen low in IDLE; fifo_data is valid the following cycle.
module fifo_uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int PARITY_EN    = 0
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       fifo_empty,
   input  logic [7:0] fifo_data,
   output logic       fifo_rd_en,
   output logic       tx,
   output logic       busy,
   output logic [2:0] state_dbg
);

   localparam logic [2:0] DATA_LAST = 3'(DATA_BITS - 1);
   localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

   state_e     state_q;
   logic [7:0] shreg_q;
   logic [2:0] idx_q;
   logic       parity_q;
   logic       tx_q;
   logic       busy_q;
   logic       rd_en_q;
   logic       bit_done;
   logic       baud_en;

   assign baud_en = (state_q == S_START) || (state_q == S_DATA) ||
                    (state_q == S_PARITY) || (state_q == S_STOP);

   uart_baud_cnt #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk     (clk),
      .rstn    (rstn),
      .clear   (state_q == S_LOAD),
      .en      (baud_en),
      .bit_done(bit_done)
   );

   // Outputs are updated on the transition into each state so tx already shows the new level.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= S_IDLE;
         shreg_q  <= '0;
         idx_q    <= '0;
         parity_q <= 1'b0;
         tx_q     <= 1'b1;
         busy_q   <= 1'b0;
         rd_en_q  <= 1'b0;
      end else begin
         rd_en_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (!fifo_empty) begin
                  state_q <= S_READ;
                  rd_en_q <= 1'b1;
                  busy_q  <= 1'b1;
               end
            end
            S_READ: state_q <= S_LOAD;
            S_LOAD: begin
               shreg_q  <= fifo_data;
               parity_q <= ^fifo_data;
               idx_q    <= '0;
               tx_q     <= 1'b0;
               state_q  <= S_START;
            end
            S_START: begin
               if (bit_done) begin
                  tx_q    <= shreg_q[0];
                  state_q <= S_DATA;
               end
            end
            S_DATA: begin
               if (bit_done) begin
                  shreg_q <= shreg_q >> 1;
                  if (idx_q == DATA_LAST) begin
                     idx_q <= '0;
                     if (PARITY_EN != 0) begin
                        tx_q    <= parity_q;
                        state_q <= S_PARITY;
                     end else begin
                        tx_q    <= 1'b1;
                        state_q <= S_STOP;
                     end
                  end else begin
                     idx_q <= idx_q + 3'd1;
                     tx_q  <= shreg_q[1];
                  end
               end
            end
            S_PARITY: begin
               if (bit_done) begin
                  tx_q    <= 1'b1;
                  state_q <= S_STOP;
               end
            end
            S_STOP: begin
               if (bit_done) begin
                  if (idx_q == STOP_LAST) begin
                     state_q <= S_IDLE;
                     busy_q  <= 1'b0;
                  end else begin
                     idx_q <= idx_q + 3'd1;
                  end
               end
            end
            default: begin
               state_q <= S_IDLE;
               tx_q    <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign fifo_rd_en = rd_en_q;
   assign tx         = tx_q;
   assign busy       = busy_q;
   assign state_dbg  = state_q;

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Serial transmitter that drains the 4-entry byte FIFO directly downstream of it and sends each byte as an asynchronous 8N1 (optionally 8E1) UART frame on a single `tx` line. It pops the FIFO through the FIFO's `rd_en`/`empty`/`data_out` port, which has one cycle of registered read latency, and sends frames back-to-back while the FIFO is non-empty.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per serial bit (50 MHz / 115200). Legal range is 2 and above.
- `PARITY_EN`, default 0: when 1, an even-parity bit is inserted between the data bits and the stop bit.
- `clk`  in  1  single system clock, rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `fifo_empty`  in  1  FIFO `empty` flag.
- `fifo_data`  in  8  FIFO `data_out`. Valid on the cycle after a pop.
- `fifo_rd_en`  out  1  pop request to the FIFO. It is a one-cycle pulse per byte.
- `tx`  out  1  serial line. Idles high.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- FSM states: IDLE, READ, LOAD, START, DATA, PARITY, STOP.
- **IDLE**
  - `tx`=1.
  - If `fifo_empty`=0, go to READ. Otherwise stay in IDLE.
  - `fifo_empty` is sampled only in IDLE and ignored in every other state.
- **READ**
  - `fifo_rd_en`=1 for exactly this one cycle. It is 0 in every other state.
  - Go to LOAD unconditionally.
- **LOAD**
  - Capture `fifo_data` into the 8-bit shift register.
  - Compute parity as the XOR of the 8 bits.
  - Go to START.
- **START**: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA.
- **DATA**
  - Send 8 bits LSB first, each held for CLKS_PER_BIT cycles.
  - A 3-bit index counts 0..7.
  - After bit 7: go to PARITY if PARITY_EN=1, else go to STOP.
- **PARITY**: `tx`=parity bit for CLKS_PER_BIT cycles, then go to STOP.
- **STOP**: `tx`=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Baud counter
  - Width is $clog2(CLKS_PER_BIT).
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
  - Cleared on entry to START.
- `busy` = (state != IDLE).
- `tx`, `busy` and `fifo_rd_en` are registered outputs (no combinational path from inputs).

## Timing
- Reset values: state=IDLE, `tx`=1, `busy`=0, `fifo_rd_en`=0, counters=0, shift register=0.
- Pop latency
  - Let cycle N be the IDLE cycle in which `fifo_empty`=0.
  - `fifo_rd_en` is high during cycle N+1.
  - `fifo_data` is sampled in cycle N+2 (LOAD).
  - `tx` falls at the edge ending cycle N+2.
- Frame length with `tx` active: (10+PARITY_EN)·CLKS_PER_BIT cycles.
- Back-to-back frames
  - The last STOP cycle is followed by IDLE, READ, LOAD, so `tx` stays high for exactly 3 extra cycles between frames.
  - Frame period is therefore (10+PARITY_EN)·CLKS_PER_BIT+3 cycles.
- Full FIFO
  - The FIFO holds at most 3 bytes in practice.
  - All of them are sent consecutively with no other gaps.
- Empty during a frame: no effect. The frame completes and then the FSM returns to IDLE and waits.
- The FIFO being written during IDLE in the same cycle `fifo_empty` goes low follows the normal path: the pop occurs in the next cycle.
- Reset mid-frame
  - Asynchronous effect: `tx`=1, `busy`=0 and `fifo_rd_en`=0 immediately.
  - A byte already popped is lost. No retransmit.
- Reset asserted during READ: the FIFO is reset by the same `rstn`, so no pointer mismatch can occur.

## Structure
- Shared package `uart_pkg` holds:
  - the state encoding constants (3-bit);
  - the default CLKS_PER_BIT;
  - the frame constants DATA_BITS=8 and STOP_BITS=1.
- One natural sub-module: `uart_baud_cnt`.
  - Parameterised by CLKS_PER_BIT.
  - Inputs: `clear`, `en`.
  - Output: a one-cycle `bit_done` pulse on count CLKS_PER_BIT-1.
- The FSM, shift register, bit index and parity logic live in `fifo_uart_tx`.

## Test plan
All scenarios use CLKS_PER_BIT=4 and the real FIFO instance upstream.
- Reset check: hold `rstn`=0 for 3 cycles, then release with the FIFO empty for 20 cycles. Required: `tx`=1, `busy`=0, `fifo_rd_en`=0 throughout.
- Single byte, PARITY_EN=0: write 0xA5.
  - `fifo_rd_en` pulses once for 1 cycle.
  - `tx` sequence is 0, 1,0,1,0,0,1,0,1, 1, each level held 4 cycles.
  - `busy` returns to 0 after 43 cycles, and `fifo_empty`=1 at the end.
- Burst: fill the FIFO with 0x01, 0x02, 0x03.
  - Three frames are sent in order, decoded by a bench UART monitor.
  - Exactly 3 idle-high cycles between consecutive stop and start bits.
  - Exactly 3 `fifo_rd_en` pulses in total.
- Parity, PARITY_EN=1: send 0x07, then 0x03. Required parity bits are 1 and 0, and each frame is 44 cycles long.
- Mid-frame reset: assert `rstn` during DATA bit 3 of 0xFF. Required: `tx`=1 on the same cycle (asynchronous), the FSM is in IDLE, and no pop occurs after release.
- Write during transmission: write 0x55 while 0xAA is in DATA. Required: 0x55 is popped only after the 0xAA stop bit ends, with the 3-cycle gap.
